// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store FIFO with load forwarding; STORE_BUF_COALESCE_EN merges same-word stores
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  input  logic                     drain_stall,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [29:0]      entry_addr [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             accept;
  logic             coalesce;
  logic             push;
  logic             pop;
  logic             unused_bits;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign st_ready = !full;
  assign dm_we    = !empty && !drain_stall;
  assign dm_addr  = empty ? 32'h0 : {entry_addr[head], 2'b00};
  assign dm_wdata = empty ? 32'h0 : entry_data[head];

  assign accept = st_valid && st_ready;
  assign pop    = dm_we;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] tail_prev;
  assign tail_prev = tail - PTR_W'(1);
  // Merging into an entry that leaves at this same edge would lose the new data.
  assign coalesce = accept && !empty
                 && (entry_addr[tail_prev][ADDR_WIDTH-3:0] == st_addr[ADDR_WIDTH-1:2])
                 && ((count >= CNT_W'(2)) || !dm_we);
`else
  assign coalesce = 1'b0;
`endif

  assign push = accept && !coalesce;

  assign unused_bits = ^{st_addr[1:0], ld_addr};

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) &&
          (entry_addr[head + PTR_W'(i)][ADDR_WIDTH-3:0] == ld_addr[ADDR_WIDTH-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = entry_data[head + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payloads are qualified by the pointers, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= st_addr[31:2];
      entry_data[tail] <= st_data;
    end
`ifdef STORE_BUF_COALESCE_EN
    if (coalesce) entry_data[tail_prev] <= st_data;
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        drain_stall;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] sb[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(12)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .drain_stall(drain_stall),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side monitor: every write must match the oldest outstanding store.
  always @(negedge clk) begin
    if (reset && dm_we) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL dm_write_unexpected: got addr %h data %h, required no write", dm_addr, dm_wdata);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({dm_addr, dm_wdata} !== e) begin
          n_miss++;
          $display("FAIL dm_write: got addr %h data %h, required addr %h data %h",
                   dm_addr, dm_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int bound);
    int k;
    k = 0;
    while (!empty && k < bound) begin
      step();
      k++;
    end
    check("drain_done", {31'b0, empty}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; drain_stall = 1'b0;
    step(); step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_empty",    {31'b0, empty},    32'd1);
    check("rst_full",     {31'b0, full},     32'd0);
    check("rst_st_ready", {31'b0, st_ready}, 32'd1);
    check("rst_dm_we",    {31'b0, dm_we},    32'd0);
    check("rst_dm_addr",  dm_addr,           32'h0);
    check("rst_dm_wdata", dm_wdata,          32'h0);
    check("rst_ld_hit",   {31'b0, ld_hit},   32'd0);
    check("rst_ld_data",  ld_data,           32'h0);
    check("rst_count",    {29'b0, count},    32'd0);

    // Single store, unstalled: visible on the memory port the cycle after accept
    st_valid = 1'b1; st_addr = 32'h0000_0010; st_data = 32'hDEAD_BEEF;
    sb.push_back({32'h10, 32'hDEAD_BEEF});
    step();
    st_valid = 1'b0;
    check("single_dm_we",   {31'b0, dm_we}, 32'd1);
    check("single_dm_addr", dm_addr,        32'h10);
    check("single_count",   {29'b0, count}, 32'd1);
    step();
    check("single_empty", {31'b0, empty}, 32'd1);
    check("single_we_off", {31'b0, dm_we}, 32'd0);

    // Fill under stall; fifth store must be refused
    drain_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * k); st_data = 32'hA0 + 32'(k);
      check("fill_st_ready", {31'b0, st_ready}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) sb.push_back({32'h100 + 32'(4 * k), 32'hA0 + 32'(k)});
      step();
    end
    st_valid = 1'b0;
    check("fill_full",  {31'b0, full},     32'd1);
    check("fill_count", {29'b0, count},    32'd4);
    check("fill_ready", {31'b0, st_ready}, 32'd0);
    drain_stall = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      step();
      check("drain_count", {29'b0, count}, 32'(k));
    end

    // Same-word stores under stall, forwarding and aliasing
    drain_stall = 1'b1;
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd1;
`ifndef STORE_BUF_COALESCE_EN
    sb.push_back({32'h20, 32'd1});
`endif
    step();
    st_data = 32'd2;
    sb.push_back({32'h20, 32'd2});
    step();
    st_valid = 1'b0;
    ld_addr = 32'h23; #1;
    check("fwd_hit",  {31'b0, ld_hit}, 32'd1);
    check("fwd_data", ld_data,         32'd2);
`ifdef STORE_BUF_COALESCE_EN
    check("fwd_count", {29'b0, count}, 32'd1);
`else
    check("fwd_count", {29'b0, count}, 32'd2);
`endif
    ld_addr = 32'h24; #1;
    check("nofwd_hit",  {31'b0, ld_hit}, 32'd0);
    check("nofwd_data", ld_data,         32'd0);
    ld_addr = 32'h1020; #1;
    check("alias_hit",  {31'b0, ld_hit}, 32'd1);
    check("alias_data", ld_data,         32'd2);
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'd3; ld_addr = 32'h40; #1;
    check("same_cycle_hit", {31'b0, ld_hit}, 32'd0);
    sb.push_back({32'h40, 32'd3});
    step();
    st_valid = 1'b0;
    check("after_push_data", ld_data, 32'd3);
    ld_addr = 32'h20;
    drain_stall = 1'b0; #1;
    check("draining_hit",  {31'b0, ld_hit}, 32'd1);
    check("draining_data", ld_data,         32'd2);
    wait_empty(10);

    // Sustained push+drain across several pointer wraps
    for (int i = 0; i < 16; i++) begin
      st_valid = 1'b1; st_addr = 32'h200 + 32'(4 * i); st_data = 32'h5000 + 32'(i);
      sb.push_back({32'h200 + 32'(4 * i), 32'h5000 + 32'(i)});
      step();
      check("stream_count", {29'b0, count}, 32'd1);
    end
    st_valid = 1'b0;
    step();
    check("stream_empty", {31'b0, empty}, 32'd1);

    // Mid-cycle reset discards pending stores
    drain_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1; st_addr = 32'h300 + 32'(4 * k); st_data = 32'h7000 + 32'(k);
      step();
    end
    st_valid = 1'b0;
    ld_addr = 32'h300;
    check("pre_rst_count", {29'b0, count}, 32'd3);
    #2 reset = 1'b0;
    #1;
    check("midrst_count",  {29'b0, count}, 32'd0);
    check("midrst_dm_we",  {31'b0, dm_we}, 32'd0);
    check("midrst_ld_hit", {31'b0, ld_hit}, 32'd0);
    drain_stall = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("post_rst_count", {29'b0, count}, 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
